// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store funct3 encodings, LSU response codes and LSU FSM states.
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_ILLEGAL  = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } lsu_err_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    // Unsigned byte/half codes exist only for loads.
    function automatic logic f3_legal(input logic ld, input logic [2:0] f3);
        logic ok_s;
        case (f3)
            F3_B, F3_H, F3_W: ok_s = 1'b1;
            F3_BU, F3_HU:     ok_s = ld;
            default:          ok_s = 1'b0;
        endcase
        return ok_s;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: legality/alignment checks, byte enables,
// store-lane replication and load lane selection with sign/zero extension.
module lsu_align
    import rv32i_pkg::*;
(
    input  logic        ld,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        illegal,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] ldata
);

    logic [15:0] half_s;
    logic [7:0]  byte_s;

    // Decode access size into enables/lanes and extract the addressed load bytes.
    always_comb begin
        illegal    = ~f3_legal(ld, funct3);
        half_s     = offset[1] ? rdata[31:16] : rdata[15:0];
        byte_s     = offset[0] ? half_s[15:8] : half_s[7:0];
        misaligned = 1'b0;
        be         = 4'b0000;
        wdata_lane = 32'h0000_0000;
        ldata      = 32'h0000_0000;
        case (funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
            end
            2'b01: begin
                misaligned = offset[0];
                be         = 4'b0011 << offset;
                wdata_lane = {2{wdata[15:0]}};
            end
            2'b10: begin
                misaligned = (offset != 2'b00);
                be         = 4'b1111;
                wdata_lane = wdata;
            end
            default: begin
                misaligned = 1'b0;
                be         = 4'b0000;
                wdata_lane = 32'h0000_0000;
            end
        endcase
        case (funct3)
            F3_B:    ldata = {{24{byte_s[7]}}, byte_s};
            F3_H:    ldata = {{16{half_s[15]}}, half_s};
            F3_W:    ldata = rdata;
            F3_BU:   ldata = {24'h00_0000, byte_s};
            F3_HU:   ldata = {16'h0000, half_s};
            default: ldata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one outstanding access, IDLE -> ACCESS -> RESP,
// with alignment/legality checks and an ack timeout.
module lsu
    import rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT = 32'd16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_ld_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        rsp_valid_o,
    output logic        rsp_wr_o,
    output logic [4:0]  rsp_rd_o,
    output logic [31:0] rsp_data_o,
    output logic [1:0]  rsp_err_o
);

    localparam logic [7:0] TO_LAST_C = 8'(TIMEOUT - 32'd1);

    lsu_state_e  state_r, state_nxt_s;
    logic [7:0]  cnt_r, cnt_nxt_s;
    logic        ready_r, ready_nxt_s;
    logic        ld_r, ld_nxt_s;
    logic [2:0]  f3_r, f3_nxt_s;
    logic [1:0]  off_r, off_nxt_s;
    logic [4:0]  rd_r, rd_nxt_s;
    logic        mem_req_r, mem_req_nxt_s;
    logic        mem_we_r, mem_we_nxt_s;
    logic [31:0] mem_addr_r, mem_addr_nxt_s;
    logic [3:0]  mem_be_r, mem_be_nxt_s;
    logic [31:0] mem_wdata_r, mem_wdata_nxt_s;
    logic        rsp_valid_r, rsp_valid_nxt_s;
    logic        rsp_wr_r, rsp_wr_nxt_s;
    logic [4:0]  rsp_rd_r, rsp_rd_nxt_s;
    logic [31:0] rsp_data_r, rsp_data_nxt_s;
    logic [1:0]  rsp_err_r, rsp_err_nxt_s;

    logic        al_ld_s;
    logic [2:0]  al_f3_s;
    logic [1:0]  al_off_s;
    logic        illegal_s, misaligned_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_lane_s, ldata_s;

    // In IDLE the aligner classifies the incoming request; afterwards it works on the captured copy.
    assign al_ld_s  = (state_r == ST_IDLE) ? req_ld_i          : ld_r;
    assign al_f3_s  = (state_r == ST_IDLE) ? req_funct3_i      : f3_r;
    assign al_off_s = (state_r == ST_IDLE) ? req_addr_i[1:0]   : off_r;

    lsu_align u_align (
        .ld         (al_ld_s),
        .funct3     (al_f3_s),
        .offset     (al_off_s),
        .wdata      (req_wdata_i),
        .rdata      (mem_rdata_i),
        .illegal    (illegal_s),
        .misaligned (misaligned_s),
        .be         (be_s),
        .wdata_lane (wdata_lane_s),
        .ldata      (ldata_s)
    );

    // Next-state and next-output computation.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        ld_nxt_s        = ld_r;
        f3_nxt_s        = f3_r;
        off_nxt_s       = off_r;
        rd_nxt_s        = rd_r;
        mem_req_nxt_s   = mem_req_r;
        mem_we_nxt_s    = mem_we_r;
        mem_addr_nxt_s  = mem_addr_r;
        mem_be_nxt_s    = mem_be_r;
        mem_wdata_nxt_s = mem_wdata_r;
        rsp_valid_nxt_s = 1'b0;
        rsp_wr_nxt_s    = rsp_wr_r;
        rsp_rd_nxt_s    = rsp_rd_r;
        rsp_data_nxt_s  = rsp_data_r;
        rsp_err_nxt_s   = rsp_err_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid_i && ready_r) begin
                    ld_nxt_s  = req_ld_i;
                    f3_nxt_s  = req_funct3_i;
                    off_nxt_s = req_addr_i[1:0];
                    rd_nxt_s  = req_rd_i;
                    if (illegal_s || misaligned_s) begin
                        state_nxt_s     = ST_RESP;
                        rsp_valid_nxt_s = 1'b1;
                        rsp_wr_nxt_s    = 1'b0;
                        rsp_rd_nxt_s    = req_rd_i;
                        rsp_data_nxt_s  = 32'h0000_0000;
                        rsp_err_nxt_s   = illegal_s ? ERR_ILLEGAL : ERR_MISALIGN;
                    end else begin
                        state_nxt_s     = ST_ACCESS;
                        cnt_nxt_s       = 8'd0;
                        mem_req_nxt_s   = 1'b1;
                        mem_we_nxt_s    = ~req_ld_i;
                        mem_addr_nxt_s  = {req_addr_i[31:2], 2'b00};
                        mem_be_nxt_s    = be_s;
                        mem_wdata_nxt_s = wdata_lane_s;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (mem_ack_i) begin
                    state_nxt_s     = ST_RESP;
                    mem_req_nxt_s   = 1'b0;
                    rsp_valid_nxt_s = 1'b1;
                    rsp_rd_nxt_s    = rd_r;
                    rsp_err_nxt_s   = ERR_OK;
                    if (ld_r) begin
                        rsp_wr_nxt_s   = (rd_r != 5'd0);
                        rsp_data_nxt_s = ldata_s;
                    end else begin
                        rsp_wr_nxt_s   = 1'b0;
                        rsp_data_nxt_s = 32'h0000_0000;
                    end
                end else if (cnt_r == TO_LAST_C) begin
                    state_nxt_s     = ST_RESP;
                    mem_req_nxt_s   = 1'b0;
                    rsp_valid_nxt_s = 1'b1;
                    rsp_wr_nxt_s    = 1'b0;
                    rsp_rd_nxt_s    = rd_r;
                    rsp_data_nxt_s  = 32'h0000_0000;
                    rsp_err_nxt_s   = ERR_TIMEOUT;
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                mem_req_nxt_s = 1'b0;
            end
        endcase
        ready_nxt_s = (state_nxt_s == ST_IDLE);
    end

    // State and output registers; reset aborts any in-flight access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            ready_r     <= 1'b1;
            ld_r        <= 1'b0;
            f3_r        <= 3'b000;
            off_r       <= 2'b00;
            rd_r        <= 5'd0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'h0000_0000;
            rsp_valid_r <= 1'b0;
            rsp_wr_r    <= 1'b0;
            rsp_rd_r    <= 5'd0;
            rsp_data_r  <= 32'h0000_0000;
            rsp_err_r   <= 2'd0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            ready_r     <= ready_nxt_s;
            ld_r        <= ld_nxt_s;
            f3_r        <= f3_nxt_s;
            off_r       <= off_nxt_s;
            rd_r        <= rd_nxt_s;
            mem_req_r   <= mem_req_nxt_s;
            mem_we_r    <= mem_we_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_be_r    <= mem_be_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_wr_r    <= rsp_wr_nxt_s;
            rsp_rd_r    <= rsp_rd_nxt_s;
            rsp_data_r  <= rsp_data_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
        end
    end

    assign req_ready_o = ready_r;
    assign mem_req_o   = mem_req_r;
    assign mem_we_o    = mem_we_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_be_o    = mem_be_r;
    assign mem_wdata_o = mem_wdata_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_wr_o    = rsp_wr_r;
    assign rsp_rd_o    = rsp_rd_r;
    assign rsp_data_o  = rsp_data_r;
    assign rsp_err_o   = rsp_err_r;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_lsu;

    logic        clk_i        = 1'b0;
    logic        rst_i        = 1'b1;
    logic        req_valid_i  = 1'b0;
    logic        req_ld_i     = 1'b0;
    logic [2:0]  req_funct3_i = 3'b000;
    logic [31:0] req_addr_i   = 32'h0000_0000;
    logic [31:0] req_wdata_i  = 32'h0000_0000;
    logic [4:0]  req_rd_i     = 5'd0;
    logic        mem_ack_i    = 1'b0;
    logic [31:0] mem_rdata_i  = 32'h0000_0000;
    logic        req_ready_o, mem_req_o, mem_we_o, rsp_valid_o, rsp_wr_o;
    logic [31:0] mem_addr_o, mem_wdata_o, rsp_data_o;
    logic [3:0]  mem_be_o;
    logic [4:0]  rsp_rd_o;
    logic [1:0]  rsp_err_o;

    always #5 clk_i = ~clk_i;

    lsu #(.TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_ld_i(req_ld_i),
        .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_rd_i(req_rd_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_wr_o(rsp_wr_o), .rsp_rd_o(rsp_rd_o),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [1:0]  err;
    } rsp_t;

    typedef struct {
        logic        ld;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] lane;
        logic        wr;
        logic [31:0] data;
    } vec_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    function automatic rsp_t mk(input logic wr, input logic [4:0] rd, input logic [31:0] data,
                                input logic [1:0] err);
        rsp_t r;
        r.wr = wr; r.rd = rd; r.data = data; r.err = err;
        return r;
    endfunction

    // Monitor: every response pulse must match the oldest expected response.
    always @(negedge clk_i) begin
        if (rsp_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", {31'd0, rsp_valid_o}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_wr", {31'd0, rsp_wr_o}, {31'd0, mon_e.wr});
                chk("rsp_err", {30'd0, rsp_err_o}, {30'd0, mon_e.err});
                chk("rsp_data", rsp_data_o, mon_e.data);
                if (mon_e.wr) chk("rsp_rd", {27'd0, rsp_rd_o}, {27'd0, mon_e.rd});
            end
        end
    end

    // Present one request at a negedge; returns at the negedge after acceptance with inputs scrambled.
    task automatic send(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
        chk("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1; req_ld_i = ld; req_funct3_i = f3;
        req_addr_i = addr; req_wdata_i = wdata; req_rd_i = rd;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0; req_ld_i = ~ld; req_funct3_i = 3'b111;
        req_addr_i = ~addr; req_wdata_i = ~wdata; req_rd_i = ~rd;
    endtask

    task automatic access1(input vec_t v);
        logic [31:0] mask;
        logic [31:0] waddr;
        mask  = {{8{v.be[3]}}, {8{v.be[2]}}, {8{v.be[1]}}, {8{v.be[0]}}};
        waddr = {v.addr[31:2], 2'b00};
        exp_q.push_back(mk(v.wr, v.rd, v.data, 2'd0));
        send(v.ld, v.f3, v.addr, v.wdata, v.rd);
        chk("mem_req", {31'd0, mem_req_o}, 32'd1);
        chk("mem_we", {31'd0, mem_we_o}, {31'd0, !v.ld});
        chk("mem_addr", mem_addr_o, waddr);
        chk("mem_be", {28'd0, mem_be_o}, {28'd0, v.be});
        if (!v.ld) chk("mem_wdata", mem_wdata_o & mask, v.lane & mask);
        mem_ack_i = 1'b1; mem_rdata_i = v.rdata;
        @(negedge clk_i);
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0000_0000;
        chk("rsp_latency2", {31'd0, rsp_valid_o}, 32'd1);
        chk("mem_req_drop", {31'd0, mem_req_o}, 32'd0);
        @(negedge clk_i);
        chk("rsp_one_cycle", {31'd0, rsp_valid_o}, 32'd0);
    endtask

    task automatic err_req(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [1:0] err);
        exp_q.push_back(mk(1'b0, rd, 32'h0000_0000, err));
        send(ld, f3, addr, 32'h1234_5678, rd);
        chk("err_no_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("err_rsp_1cyc", {31'd0, rsp_valid_o}, 32'd1);
        @(negedge clk_i);
        chk("err_rsp_pulse", {31'd0, rsp_valid_o}, 32'd0);
    endtask

    initial begin
        int n;
        vecs[0] = '{1'b1, 3'b000, 32'h0000_0103, 32'h0, 5'd5, 32'h80FF_0000, 4'b1000, 32'h0, 1'b1, 32'hFFFF_FF80};
        vecs[1] = '{1'b1, 3'b001, 32'h0000_0002, 32'h0, 5'd6, 32'h8001_0000, 4'b1100, 32'h0, 1'b1, 32'hFFFF_8001};
        vecs[2] = '{1'b1, 3'b100, 32'h0000_0001, 32'h0, 5'd7, 32'h0000_F000, 4'b0010, 32'h0, 1'b1, 32'h0000_00F0};
        vecs[3] = '{1'b1, 3'b000, 32'h0000_0000, 32'h0, 5'd8, 32'h0000_007F, 4'b0001, 32'h0, 1'b1, 32'h0000_007F};
        vecs[4] = '{1'b1, 3'b010, 32'h0000_0010, 32'h0, 5'd0, 32'h1234_5678, 4'b1111, 32'h0, 1'b0, 32'h1234_5678};
        vecs[5] = '{1'b0, 3'b000, 32'h0000_0003, 32'h0000_00A5, 5'd1, 32'h0, 4'b1000, 32'hA500_0000, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 5'd2, 32'h0, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 3'b101, 32'h0000_0000, 32'h0, 5'd9, 32'h1234_FEDC, 4'b0011, 32'h0, 1'b1, 32'h0000_FEDC};

        // Power-up reset
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_rsp_data", rsp_data_o, 32'h0000_0000);
        chk("rst_mem_be", {28'd0, mem_be_o}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        for (int i = 0; i < 8; i++) access1(vecs[i]);

        // SH with three wait cycles before ack
        exp_q.push_back(mk(1'b0, 5'd11, 32'h0000_0000, 2'd0));
        send(1'b0, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 5'd11);
        chk("sh_be", {28'd0, mem_be_o}, {28'd0, 4'b1100});
        chk("sh_we", {31'd0, mem_we_o}, 32'd1);
        chk("sh_wdata_hi", {16'd0, mem_wdata_o[31:16]}, 32'h0000_BEEF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("sh_wait_req", {31'd0, mem_req_o}, 32'd1);
            chk("sh_wait_addr", mem_addr_o, 32'h0000_0200);
        end
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        chk("sh_rsp", {31'd0, rsp_valid_o}, 32'd1);
        @(negedge clk_i);

        // Error requests: misaligned, illegal, illegal over misaligned
        err_req(1'b1, 3'b010, 32'h0000_0101, 5'd3, 2'd1);
        err_req(1'b1, 3'b011, 32'h0000_0100, 5'd3, 2'd2);
        err_req(1'b1, 3'b111, 32'h0000_0103, 5'd3, 2'd2);
        err_req(1'b0, 3'b100, 32'h0000_0000, 5'd3, 2'd2);
        err_req(1'b0, 3'b001, 32'h0000_0201, 5'd3, 2'd1);

        // Timeout: LHU with no ack
        exp_q.push_back(mk(1'b0, 5'd10, 32'h0000_0000, 2'd3));
        send(1'b1, 3'b101, 32'h0000_0002, 32'h0, 5'd10);
        chk("to_be", {28'd0, mem_be_o}, {28'd0, 4'b1100});
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (mem_req_o !== 1'b1) break;
            n++;
            @(negedge clk_i);
        end
        chk("timeout_cycles", n, 32'd16);
        chk("timeout_rsp", {31'd0, rsp_valid_o}, 32'd1);
        @(negedge clk_i);

        // Reset during ACCESS, then a late ack
        send(1'b1, 3'b010, 32'h0000_0040, 32'h0, 5'd3);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
        chk("abort_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("abort_ready", {31'd0, req_ready_o}, 32'd1);
        chk("abort_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
        @(negedge clk_i);
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0000_0000;
        chk("late_ack_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
        chk("late_ack_no_req", {31'd0, mem_req_o}, 32'd0);
        @(negedge clk_i);

        // req_valid held high: a second request is taken only once ready returns
        exp_q.push_back(mk(1'b1, 5'd4, 32'h0000_ABCD, 2'd0));
        chk("b2b_ready0", {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1; req_ld_i = 1'b1; req_funct3_i = 3'b101;
        req_addr_i = 32'h0000_0006; req_rd_i = 5'd4;
        @(negedge clk_i);
        chk("b2b_busy_access", {31'd0, req_ready_o}, 32'd0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'hABCD_1234;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        chk("b2b_busy_resp", {31'd0, req_ready_o}, 32'd0);
        chk("b2b_rsp_a", {31'd0, rsp_valid_o}, 32'd1);
        @(negedge clk_i);
        chk("b2b_ready_again", {31'd0, req_ready_o}, 32'd1);
        exp_q.push_back(mk(1'b1, 5'd4, 32'h0000_5555, 2'd0));
        @(negedge clk_i);
        req_valid_i = 1'b0;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        chk("b2b_rsp_b", {31'd0, rsp_valid_o}, 32'd1);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the max cycles waiting for mem_ack_i before abort (range 1..255).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid_i  input  1  execute presents a load/store request.
REQ-005 SHALL have port req_ready_o  output  1  LSU can accept a request this cycle.
REQ-006 SHALL have port req_ld_i  input  1  1=load, 0=store.
REQ-007 SHALL have port req_funct3_i  input  3  RV32I width/sign code.
REQ-008 SHALL have port req_addr_i  input  32  byte address.
REQ-009 SHALL have port req_wdata_i  input  32  store data, LSB-aligned.
REQ-010 SHALL have port req_rd_i  input  5  load destination register.
REQ-011 SHALL have port mem_req_o  output  1  memory access request.
REQ-012 SHALL have port mem_we_o  output  1  1=write.
REQ-013 SHALL have port mem_addr_o  output  32  word address (bits[1:0]=0).
REQ-014 SHALL have port mem_be_o  output  4  byte enables.
REQ-015 SHALL have port mem_wdata_o  output  32  lane-shifted store data.
REQ-016 SHALL have port mem_ack_i  input  1  memory completes access (rdata valid same cycle).
REQ-017 SHALL have port mem_rdata_i  input  32  read word.
REQ-018 SHALL have port rsp_valid_o  output  1  one-cycle completion pulse.
REQ-019 SHALL have port rsp_wr_o  output  1  write rsp_data_o to rsp_rd_o.
REQ-020 SHALL have port rsp_rd_o  output  5  destination register.
REQ-021 SHALL have port rsp_data_o  output  32  extended load data.
REQ-022 SHALL have port rsp_err_o  output  2  0=ok, 1=misaligned, 2=illegal funct3, 3=timeout.

Function
REQ-023 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; req_ready_o=1 only in IDLE; request accepted when req_valid_i & req_ready_o.
REQ-024 SHALL capture all req_* fields into registers on acceptance; later input changes ignored.
REQ-025 SHALL decode loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; any other code -> illegal.
REQ-026 SHALL flag misaligned when halfword addr[0]=1 or word addr[1:0]!=0.
REQ-027 SHALL go IDLE -> RESP directly for illegal or misaligned requests, never asserting mem_req_o; illegal takes priority over misaligned.
REQ-028 SHALL hold mem_req_o=1 with stable mem_we_o/addr/be/wdata for every ACCESS cycle; mem_ack_i ignored outside ACCESS.
REQ-029 SHALL set mem_be_o: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; mem_wdata_o = wdata replicated into selected lanes.
REQ-030 SHALL on ack in ACCESS register the selected lane(s), sign-extend (LB/LH) or zero-extend (LBU/LHU), move to RESP.
REQ-031 SHALL count ACCESS cycles; if TIMEOUT cycles pass without ack, drop mem_req_o and enter RESP with rsp_err_o=3.
REQ-032 SHALL in RESP assert rsp_valid_o for exactly one cycle, then return to IDLE; minimum accepted-to-response latency 2 cycles (ack in first ACCESS cycle).
REQ-033 SHALL assert rsp_wr_o only for error-free loads with rd!=0; rsp_data_o=0 for stores and errors.
REQ-034 SHALL hold outputs stable between responses; rsp_* valid only while rsp_valid_o=1.

Reset
REQ-035 SHALL on rst_i=1 at a clock edge enter IDLE, clear timeout counter, drive all outputs 0 except req_ready_o=1 from the following cycle.
REQ-036 SHALL abort an in-flight access on reset (mem_req_o low next cycle, no rsp_valid_o); a late mem_ack_i is ignored.

Structure
REQ-037 SHALL take funct3 encodings, rsp_err codes and FSM state encodings from shared package rv32i_pkg.
REQ-038 SHALL place lane selection, byte-enable generation and sign/zero extension in combinational sub-module lsu_align.

Verification
REQ-039 SHALL test LB addr 0x103, mem_rdata 0x80FF_0000, ack 1st cycle -> be 4'b1000, rsp_data 0xFFFF_FF80, rsp_wr=1, rsp 2 cycles after accept.
REQ-040 SHALL test SH addr 0x202, wdata 0x0000_BEEF, ack after 3 waits -> be 4'b1100, wdata[31:16]=0xBEEF, rsp_wr=0, err=0.
REQ-041 SHALL test LW addr 0x101 -> no mem_req_o, rsp_err=1 one cycle after accept; funct3=011 load -> rsp_err=2.
REQ-042 SHALL test LHU addr 0x2 with no ack, TIMEOUT=16 -> mem_req_o high 16 cycles then low, rsp_err=3.
REQ-043 SHALL test reset asserted during ACCESS, then ack next cycle -> no rsp_valid_o, req_ready_o=1 after reset.
REQ-044 SHALL test LW with rd=0 -> rsp_valid_o=1, rsp_wr=0; back-to-back requests accepted only while req_ready_o=1.
